ram_bist: RTL and testbench

RAM_BIST -- requirements
Module: ram_bist

---
 rtl/sdc_ram_pkg.sv | 39 +++
 rtl/ram_bist_if.sv | 20 ++
 rtl/ram_bist_pat.sv | 21 ++
 rtl/ram_bist.sv | 192 +++++++++++++++++++
 tb/tb_ram_bist.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/sdc_ram_pkg.sv
// Shared definitions for the RAM BIST block.
//   - ADDR_W_DEF / DATA_W_DEF : default RAM address and data widths
//   - state_t                 : BIST controller states
//   - pat_fn                  : test pattern generator
// The pattern repeats the address bits cyclically across the data word,
// e.g. {a[DATA_W-ADDR_W-1:0], a} when DATA_W <= 2*ADDR_W. That word is XORed
// with the seed, and the whole result is inverted for the second pass.
package sdc_ram_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 8;
  localparam int PAT_MAX_W  = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // a and seed are zero-extended by the caller; the caller truncates the result.
  function automatic logic [PAT_MAX_W-1:0] pat_fn(
    input logic [PAT_MAX_W-1:0] a,
    input logic                 p,
    input logic [PAT_MAX_W-1:0] seed,
    input int                   aw
  );
    logic [PAT_MAX_W-1:0] v;
    v = '0;
    for (int k = 0; k < PAT_MAX_W; k++) begin
      if (k * aw < PAT_MAX_W) v = v | (a << (k * aw));
    end
    v = v ^ seed;
    if (p) v = ~v;
    return v;
  endfunction

endpackage

// File: rtl/ram_bist_if.sv
// RAM-side bus of the BIST controller.
//   we   : write enable
//   addr : RAM address
//   din  : write data into the RAM
//   dout : read data from the RAM (1-cycle read latency)
// The master modport is the BIST side. The slave modport is the RAM side.
interface ram_bist_if
  import sdc_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;

  modport master (output we, output addr, output din, input dout);
  modport slave  (input we, input addr, input din, output dout);
endinterface

// File: rtl/ram_bist_pat.sv
// Combinational test-pattern generator. It is a thin wrapper around
// sdc_ram_pkg::pat_fn at the module's widths.
//   a    : RAM address
//   p    : pass bit (0 = true pattern, 1 = inverted)
//   seed : run seed
//   pat  : pattern word for address a
module ram_bist_pat
  import sdc_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [ADDR_W-1:0] a,
  input  logic              p,
  input  logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] pat
);

  assign pat = DATA_W'(pat_fn(PAT_MAX_W'(a), p, PAT_MAX_W'(seed), ADDR_W));

endmodule

// File: rtl/ram_bist.sv
// Two-pass march-style RAM BIST controller.
// Each pass writes pat(a,p) to every address and then reads every address
// back. Pass 0 uses p=0 and pass 1 uses p=1, which inverts the pattern.
// The RAM read latency is 1 cycle. A DRAIN cycle after the last read
// absorbs the final compare.
// Ports:
//   clk, rst : clock; synchronous active-high reset
//   start    : run request, honoured only in IDLE
//   seed     : pattern seed, captured when start is accepted
//   busy     : high in WR, RD and DRAIN
//   done     : one-cycle completion pulse
//   pass     : result of the last completed run
//   err_cnt  : mismatch count of the current or last run
//   ram      : RAM bus (ram_bist_if.master)
// Optional feature, enabled by defining RAM_BIST_ERRLOG_EN:
//   err_valid/err_addr/err_exp/err_got log the first mismatch of a run.
module ram_bist
  import sdc_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W+1:0] err_cnt,
  ram_bist_if.master        ram
`ifdef RAM_BIST_ERRLOG_EN
  ,
  output logic              err_valid,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_exp,
  output logic [DATA_W-1:0] err_got
`endif
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W+1:0] CNT_ONE   = {{(ADDR_W+1){1'b0}}, 1'b1};

  state_t            state;
  logic              p;
  logic [DATA_W-1:0] seed_q;

  logic              cmp_vld_p1;
  logic [ADDR_W-1:0] cmp_addr_p1;

  logic [ADDR_W-1:0] wr_addr;
  logic              wr_p;
  logic [DATA_W-1:0] wr_seed;
  logic [DATA_W-1:0] wr_pat;
  logic [DATA_W-1:0] exp_pat;
  logic              mismatch;

  // ram.din is registered, so the write pattern is computed from the
  // address, pass bit and seed that take effect on the next edge.
  always_comb begin
    wr_addr = '0;
    wr_p    = p;
    wr_seed = seed_q;
    case (state)
      ST_IDLE: begin
        wr_p    = 1'b0;
        wr_seed = seed;
      end
      ST_WR:    wr_addr = ram.addr + ADDR_ONE;
      ST_DRAIN: wr_p    = 1'b1;
      default:  ;
    endcase
  end

  ram_bist_pat #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_pat_wr (
    .a    (wr_addr),
    .p    (wr_p),
    .seed (wr_seed),
    .pat  (wr_pat)
  );

  ram_bist_pat #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_pat_exp (
    .a    (cmp_addr_p1),
    .p    (p),
    .seed (seed_q),
    .pat  (exp_pat)
  );

  // Stage p1: read data for the address issued in the previous cycle.
  assign mismatch = cmp_vld_p1 && (ram.dout != exp_pat);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      p          <= 1'b0;
      ram.we     <= 1'b0;
      ram.addr   <= '0;
      ram.din    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      cmp_vld_p1 <= 1'b0;
`ifdef RAM_BIST_ERRLOG_EN
      err_valid  <= 1'b0;
      err_addr   <= '0;
      err_exp    <= '0;
      err_got    <= '0;
`endif
    end else begin
      done        <= 1'b0;
      // Stage p0 -> p1: remember which address was read.
      cmp_vld_p1  <= (state == ST_RD);
      cmp_addr_p1 <= ram.addr;

      if (mismatch) err_cnt <= err_cnt + CNT_ONE;
`ifdef RAM_BIST_ERRLOG_EN
      if (mismatch && !err_valid) begin
        err_valid <= 1'b1;
        err_addr  <= cmp_addr_p1;
        err_exp   <= exp_pat;
        err_got   <= ram.dout;
      end
`endif

      case (state)
        ST_IDLE: begin
          if (start) begin
            seed_q   <= seed;
            err_cnt  <= '0;
            pass     <= 1'b0;
            p        <= 1'b0;
            busy     <= 1'b1;
            ram.we   <= 1'b1;
            ram.addr <= '0;
            ram.din  <= wr_pat;
            state    <= ST_WR;
`ifdef RAM_BIST_ERRLOG_EN
            err_valid <= 1'b0;
            err_addr  <= '0;
            err_exp   <= '0;
            err_got   <= '0;
`endif
          end
        end

        ST_WR: begin
          if (ram.addr == ADDR_LAST) begin
            ram.we   <= 1'b0;
            ram.din  <= '0;
            ram.addr <= '0;
            state    <= ST_RD;
          end else begin
            ram.addr <= wr_addr;
            ram.din  <= wr_pat;
          end
        end

        ST_RD: begin
          if (ram.addr == ADDR_LAST) begin
            ram.addr <= '0;
            state    <= ST_DRAIN;
          end else begin
            ram.addr <= ram.addr + ADDR_ONE;
          end
        end

        ST_DRAIN: begin
          if (!p) begin
            p        <= 1'b1;
            ram.we   <= 1'b1;
            ram.addr <= '0;
            ram.din  <= wr_pat;
            state    <= ST_WR;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            // The final compare is still in flight in this cycle.
            pass  <= (err_cnt == '0) && !mismatch;
            state <= ST_DONE;
          end
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bist.sv
// Testbench for ram_bist with a behavioural 1-cycle-latency RAM model.
// Each run pushes its expected completion (cycle, pass, err_cnt, busy
// length) into a queue. A monitor pops and checks an entry on every done
// pulse.
// Define RAM_BIST_ERRLOG_EN to include the first-error-log scenario.
module tb_ram_bist;
  import sdc_ram_pkg::*;

  localparam int AW = 6;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] seed;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW+1:0] err_cnt;
`ifdef RAM_BIST_ERRLOG_EN
  logic          err_valid;
  logic [AW-1:0] err_addr;
  logic [DW-1:0] err_exp;
  logic [DW-1:0] err_got;
`endif

  always #5 clk = ~clk;

  ram_bist_if #(.ADDR_W(AW), .DATA_W(DW)) ram_if ();

  ram_bist #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .seed    (seed),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .err_cnt (err_cnt),
    .ram     (ram_if)
`ifdef RAM_BIST_ERRLOG_EN
    ,
    .err_valid (err_valid),
    .err_addr  (err_addr),
    .err_exp   (err_exp),
    .err_got   (err_got)
`endif
  );

  // Behavioural RAM with optional stuck-at-0 on bit 0 and a one-shot
  // corruption of the read of address 5.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          stuck       = 1'b0;
  logic          corrupt_arm = 1'b0;

  always @(posedge clk) begin : ram_model
    logic [DW-1:0] rd;
    if (ram_if.we) mem[ram_if.addr] <= ram_if.din;
    rd = mem[ram_if.addr];
    if (stuck) rd[0] = 1'b0;
    if (corrupt_arm && !ram_if.we && ram_if.addr == 6'd5) rd = 8'h44;
    ram_if.dout <= rd;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  typedef struct {
    int cyc;
    int pass;
    int err;
  } exp_t;

  exp_t sb[$];

  // Monitor: samples 1 time unit after each rising edge.
  int   busy_cnt  = 0;
  logic done_prev = 1'b0;
  always @(posedge clk) begin : monitor
    logic rst_edge;
    exp_t e;
    rst_edge = rst;
    #1;
    if (rst_edge) busy_cnt = 0;
    else if (busy) busy_cnt++;
    if (done_prev) chk("done_one_cycle", done, 0);
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("done_pass", pass, e.pass);
        chk("done_err_cnt", err_cnt, e.err);
        chk("busy_cycles", busy_cnt, 258);
      end
      busy_cnt = 0;
    end
    done_prev = done;
  end

  task automatic wait_sb(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // Returns the cycle counter value seen in cycle 1 of the run.
  task automatic start_run(input logic [DW-1:0] s, output int a);
    repeat (3) @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = cyc;
  endtask

  initial begin
    int a;
    rst   = 1'b1;
    start = 1'b0;
    seed  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_we", ram_if.we, 0);
    chk("rst_addr", ram_if.addr, 0);
    chk("rst_din", ram_if.din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err_cnt", err_cnt, 0);

    // Clean run, seed 0x00
    start_run(8'h00, a);
    chk("first_wr_addr", ram_if.addr, 0);
    chk("first_wr_din", ram_if.din, 8'h00);
    @(negedge clk);
    chk("second_wr_din", ram_if.din, 8'h41);
    sb.push_back('{a + 258, 1, 0});
    wait_sb(600);
    repeat (2) @(negedge clk);
    chk("pass_hold_clean", pass, 1);

    // Stuck-at-0 on bit 0: 32 mismatches per pass
    stuck = 1'b1;
    start_run(8'h00, a);
    sb.push_back('{a + 258, 0, 64});
    wait_sb(600);
    repeat (2) @(negedge clk);
    chk("pass_hold_stuck", pass, 0);
    chk("err_hold_stuck", err_cnt, 64);
    stuck = 1'b0;

    // Start pulses during a run are ignored
    start_run(8'h3C, a);
    sb.push_back('{a + 258, 1, 0});
    while (cyc != a + 9) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc != a + 149) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_sb(600);

    // Mid-run reset while errors are accumulating, then a clean run
    stuck = 1'b1;
    start_run(8'h11, a);
    while (cyc != a + 99) @(negedge clk);
    chk("err_cnt_nonzero_before_rst", err_cnt != 0, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_we", ram_if.we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    chk("midrst_addr", ram_if.addr, 0);
    stuck = 1'b0;
    start_run(8'hA5, a);
    sb.push_back('{a + 258, 1, 0});
    wait_sb(600);

    // Back-to-back: start held through DONE; the first run fails, the second is clean
    repeat (3) @(negedge clk);
    stuck = 1'b1;
    seed  = 8'h00;
    start = 1'b1;
    @(negedge clk);
    a = cyc;
    sb.push_back('{a + 258, 0, 64});
    sb.push_back('{a + 518, 1, 0});
    while (cyc != a + 260) @(negedge clk);
    start = 1'b0;
    stuck = 1'b0;
    chk("b2b_busy_second", busy, 1);
    chk("b2b_err_cleared", err_cnt, 0);
    wait_sb(800);

`ifdef RAM_BIST_ERRLOG_EN
    // First-error log: pass-0 read of address 5 returns 0x44 instead of 0x45
    corrupt_arm = 1'b1;
    start_run(8'h00, a);
    sb.push_back('{a + 258, 0, 1});
    while (cyc != a + 129) @(negedge clk);
    corrupt_arm = 1'b0;
    wait_sb(600);
    chk("log_valid", err_valid, 1);
    chk("log_addr", err_addr, 8'h05);
    chk("log_exp", err_exp, 8'h45);
    chk("log_got", err_got, 8'h44);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
